// File: rtl/model_ntm_vector_transmitter.sv
// model_ntm_vector_transmitter: buffers a vector and streams it element-serially over valid/ready
module model_ntm_vector_transmitter #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int ADDR_SIZE    = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WRITE_ENABLE,
    input  logic [ADDR_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0] WRITE_DATA,
    input  logic                 START,
    input  logic [ADDR_SIZE:0]   SIZE_IN,
    input  logic                 DATA_OUT_READY,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 DATA_OUT_ENABLE,
    output logic                 READY,
    output logic                 BUSY
);
    localparam int DEPTH = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(DEPTH);
    typedef enum logic [CONTROL_SIZE-1:0] {
        STARTER_STATE = CONTROL_SIZE'(0),
        SEND_STATE    = CONTROL_SIZE'(1)
    } state_t;
    state_t state, state_n;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] index, index_n;
    logic [ADDR_SIZE:0]   size, size_n, size_clamp;
    logic [DATA_SIZE-1:0] data_n;
    logic                 enable_n, ready_n, busy_n, last;
    assign size_clamp = (SIZE_IN > DEPTH_W) ? DEPTH_W : SIZE_IN;
    assign last       = ({1'b0, index} + (ADDR_SIZE+1)'(1)) == size;
    // buffer has no reset so its contents survive RST
    always_ff @(posedge CLK) begin
        if (!BUSY && WRITE_ENABLE) mem[WRITE_ADDRESS] <= WRITE_DATA;
    end
    always_comb begin
        state_n  = state;
        index_n  = index;
        size_n   = size;
        data_n   = DATA_OUT;
        enable_n = DATA_OUT_ENABLE;
        ready_n  = 1'b0;
        busy_n   = BUSY;
        if (state == STARTER_STATE) begin
            if (START) begin
                size_n  = size_clamp;
                index_n = '0;
                if (size_clamp == '0) begin
                    ready_n = 1'b1;
                end else begin
                    data_n   = mem[0];
                    enable_n = 1'b1;
                    busy_n   = 1'b1;
                    state_n  = SEND_STATE;
                end
            end
        end else if (DATA_OUT_ENABLE && DATA_OUT_READY) begin
            if (last) begin
                enable_n = 1'b0;
                busy_n   = 1'b0;
                ready_n  = 1'b1;
                state_n  = STARTER_STATE;
            end else begin
                index_n = index + ADDR_SIZE'(1);
                data_n  = mem[index + ADDR_SIZE'(1)];
            end
        end
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= STARTER_STATE;
            index           <= '0;
            size            <= '0;
            DATA_OUT        <= '0;
            DATA_OUT_ENABLE <= 1'b0;
            READY           <= 1'b0;
            BUSY            <= 1'b0;
        end else begin
            state           <= state_n;
            index           <= index_n;
            size            <= size_n;
            DATA_OUT        <= data_n;
            DATA_OUT_ENABLE <= enable_n;
            READY           <= ready_n;
            BUSY            <= busy_n;
        end
    end
endmodule

// File: tb/tb_model_ntm_vector_transmitter.sv
// tb_model_ntm_vector_transmitter: directed scenario tests with hand-computed expectations
module tb_model_ntm_vector_transmitter;
    logic        CLK = 0, RST = 0;
    logic        WRITE_ENABLE = 0;
    logic [3:0]  WRITE_ADDRESS = 0;
    logic [63:0] WRITE_DATA = 0;
    logic        START = 0;
    logic [4:0]  SIZE_IN = 0;
    logic        DATA_OUT_READY = 0;
    logic [63:0] DATA_OUT;
    logic        DATA_OUT_ENABLE, READY, BUSY;
    int errors = 0, checks = 0;

    model_ntm_vector_transmitter dut (
        .CLK(CLK), .RST(RST), .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS),
        .WRITE_DATA(WRITE_DATA), .START(START), .SIZE_IN(SIZE_IN), .DATA_OUT_READY(DATA_OUT_READY),
        .DATA_OUT(DATA_OUT), .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .READY(READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic write_word(input logic [3:0] a, input logic [63:0] d);
        @(negedge CLK);
        WRITE_ENABLE = 1; WRITE_ADDRESS = a; WRITE_DATA = d;
        @(posedge CLK); #1;
        WRITE_ENABLE = 0;
    endtask

    task automatic start_xfer(input logic [4:0] n);
        @(negedge CLK);
        START = 1; SIZE_IN = n;
        @(posedge CLK); #1;
        START = 0;
    endtask

    task automatic load_base();
        for (int i = 0; i < 4; i++) write_word(4'(i), 64'((i + 1) * 10));
    endtask

    task automatic test_reset();
        #2;
        checks++; if (DATA_OUT !== 64'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", DATA_OUT); end
        checks++; if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", DATA_OUT_ENABLE); end
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", READY); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        @(negedge CLK); RST = 1;
    endtask

    task automatic test_stream();
        load_base();
        DATA_OUT_READY = 1;
        start_xfer(4);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if (DATA_OUT_ENABLE !== 1'b1 || DATA_OUT !== 64'((i + 1) * 10)) begin
                errors++; $display("FAIL stream_elem%0d got=%0d en=%b exp=%0d", i, DATA_OUT, DATA_OUT_ENABLE, (i + 1) * 10); end
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL stream_busy%0d got=%b exp=1", i, BUSY); end
        end
        @(negedge CLK);
        checks++; if (READY !== 1'b1 || DATA_OUT_ENABLE !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL stream_done ready=%b en=%b busy=%b exp 1 0 0", READY, DATA_OUT_ENABLE, BUSY); end
        @(negedge CLK);
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL stream_ready_pulse got=%b exp=0", READY); end
    endtask

    task automatic test_stall();
        logic pat [5] = '{1, 0, 0, 1, 1};
        int idx = 0;
        start_xfer(3);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++; if (DATA_OUT_ENABLE !== 1'b1 || DATA_OUT !== 64'((idx + 1) * 10) || READY !== 1'b0) begin
                errors++; $display("FAIL stall_c%0d got=%0d en=%b rdy=%b exp=%0d", c, DATA_OUT, DATA_OUT_ENABLE, READY, (idx + 1) * 10); end
            DATA_OUT_READY = pat[c];
            if (pat[c]) idx++;
        end
        @(negedge CLK);
        checks++; if (READY !== 1'b1 || DATA_OUT_ENABLE !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL stall_done ready=%b en=%b busy=%b exp 1 0 0", READY, DATA_OUT_ENABLE, BUSY); end
        @(negedge CLK);
        checks++; if (READY !== 1'b0) begin errors++; $display("FAIL stall_ready_pulse got=%b exp=0", READY); end
    endtask

    task automatic test_zero();
        start_xfer(0);
        @(negedge CLK);
        checks++; if (READY !== 1'b1 || DATA_OUT_ENABLE !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL zero_ready ready=%b en=%b busy=%b exp 1 0 0", READY, DATA_OUT_ENABLE, BUSY); end
        @(negedge CLK);
        checks++; if (READY !== 1'b0 || DATA_OUT_ENABLE !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL zero_after ready=%b en=%b busy=%b exp 0 0 0", READY, DATA_OUT_ENABLE, BUSY); end
    endtask

    task automatic test_reset_mid();
        start_xfer(4);
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (DATA_OUT !== 64'd20) begin errors++; $display("FAIL rmid_pre got=%0d exp=20", DATA_OUT); end
        RST = 0;
        #1;
        checks++; if (DATA_OUT !== 64'd0 || DATA_OUT_ENABLE !== 1'b0 || READY !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL rmid_async d=%0d en=%b rdy=%b busy=%b exp all 0", DATA_OUT, DATA_OUT_ENABLE, READY, BUSY); end
        repeat (2) @(negedge CLK);
        checks++; if (READY !== 1'b0 || DATA_OUT_ENABLE !== 1'b0) begin
            errors++; $display("FAIL rmid_hold rdy=%b en=%b exp 0 0", READY, DATA_OUT_ENABLE); end
        RST = 1;
        start_xfer(2);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++; if (DATA_OUT_ENABLE !== 1'b1 || DATA_OUT !== 64'((i + 1) * 10)) begin
                errors++; $display("FAIL rmid_elem%0d got=%0d en=%b exp=%0d", i, DATA_OUT, DATA_OUT_ENABLE, (i + 1) * 10); end
        end
        @(negedge CLK);
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL rmid_done got=%b exp=1", READY); end
    endtask

    task automatic test_back_to_back();
        start_xfer(2);
        repeat (2) @(negedge CLK);
        @(negedge CLK);
        checks++; if (READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL b2b_ready rdy=%b busy=%b exp 1 0", READY, BUSY); end
        START = 1; SIZE_IN = 3;
        @(posedge CLK); #1;
        START = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (DATA_OUT_ENABLE !== 1'b1 || DATA_OUT !== 64'((i + 1) * 10) || BUSY !== 1'b1) begin
                errors++; $display("FAIL b2b_elem%0d got=%0d en=%b busy=%b exp=%0d", i, DATA_OUT, DATA_OUT_ENABLE, BUSY, (i + 1) * 10); end
        end
        @(negedge CLK);
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", READY); end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 16; i++) write_word(4'(i), 64'(i + 1));
        start_xfer(31);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            checks++; if (DATA_OUT_ENABLE !== 1'b1 || DATA_OUT !== 64'(i + 1)) begin
                errors++; $display("FAIL clamp_elem%0d got=%0d en=%b exp=%0d", i, DATA_OUT, DATA_OUT_ENABLE, i + 1); end
            if (i == 2) begin START = 1; SIZE_IN = 2; WRITE_ENABLE = 1; WRITE_ADDRESS = 0; WRITE_DATA = 64'd99; end
            if (i == 3) begin START = 0; WRITE_ENABLE = 0; end
        end
        @(negedge CLK);
        checks++; if (READY !== 1'b1 || DATA_OUT_ENABLE !== 1'b0) begin
            errors++; $display("FAIL clamp_done rdy=%b en=%b exp 1 0", READY, DATA_OUT_ENABLE); end
        @(negedge CLK);
        checks++; if (READY !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL clamp_ignored_start rdy=%b busy=%b exp 0 0", READY, BUSY); end
        start_xfer(1);
        @(negedge CLK);
        checks++; if (DATA_OUT !== 64'd1) begin errors++; $display("FAIL clamp_mem0_kept got=%0d exp=1", DATA_OUT); end
        @(negedge CLK);
        checks++; if (READY !== 1'b1) begin errors++; $display("FAIL clamp_single_done got=%b exp=1", READY); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_zero();
        DATA_OUT_READY = 1;
        test_reset_mid();
        test_back_to_back();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/model_ntm_vector_transmitter.md
# model_ntm_vector_transmitter

Element-serial vector transmitter for the NTM datapath. It holds a vector of up to 2**ADDR_SIZE words of DATA_SIZE bits in a local buffer and, on START, streams SIZE_IN elements out over a valid/ready handshake. The transfer finishes with a one-cycle READY pulse. It is the sending end of the element-serial vector interface that the NTM vector and matrix units consume with DATA_IN / DATA_IN_ENABLE.

## Interface
- DATA_SIZE, 64, element width in bits
- CONTROL_SIZE, 4, width of the internal state register
- ADDR_SIZE, 4, buffer address width; DEPTH = 2**ADDR_SIZE entries
- CLK  input  1  clock, rising edge
- RST  input  1  reset; asynchronous, active-low
- WRITE_ENABLE  input  1  buffer load strobe
- WRITE_ADDRESS  input  ADDR_SIZE  buffer load address
- WRITE_DATA  input  DATA_SIZE  buffer load word
- START  input  1  begin transfer; sampled only while BUSY=0
- SIZE_IN  input  ADDR_SIZE+1  number of elements to send; latched on accepted START
- DATA_OUT_READY  input  1  consumer accepts the current element
- DATA_OUT  output  DATA_SIZE  current element
- DATA_OUT_ENABLE  output  1  DATA_OUT is valid
- READY  output  1  one-cycle pulse, transfer complete
- BUSY  output  1  transfer in progress

## Operation
- States, encoded in CONTROL_SIZE bits:
  - STARTER_STATE = ZERO_CONTROL: idle.
  - SEND_STATE = ONE_CONTROL: streaming.
- Buffer:
  - Write port: with BUSY=0 and WRITE_ENABLE=1, mem[WRITE_ADDRESS] <= WRITE_DATA.
  - Writes while BUSY=1 are dropped.
  - The buffer is not reset. Contents survive RST.
- STARTER_STATE, START=1:
  - Latch size = min(SIZE_IN, DEPTH) and set index = 0.
  - If size = 0: stay in STARTER_STATE and pulse READY next cycle. DATA_OUT_ENABLE never rises.
  - Otherwise: DATA_OUT <= mem[0], DATA_OUT_ENABLE <= 1, BUSY <= 1, and go to SEND_STATE.
- SEND_STATE:
  - A transfer occurs on any cycle with DATA_OUT_ENABLE=1 and DATA_OUT_READY=1.
  - Non-last transfer (index < size-1):
    - index++
    - DATA_OUT <= mem[index+1]
    - DATA_OUT_ENABLE stays 1.
  - Last transfer (index = size-1):
    - DATA_OUT_ENABLE <= 0, BUSY <= 0, READY <= 1.
    - Go to STARTER_STATE.
  - No transfer: DATA_OUT, DATA_OUT_ENABLE and index hold. DATA_OUT must not change while valid and not accepted.
  - START is ignored.
- READY:
  - Registered and high for exactly one cycle per accepted START, including size 0.
  - A START sampled during the READY cycle is accepted, because the block is in STARTER_STATE with BUSY=0.
- Sizes: SIZE_IN = DEPTH sends all entries. SIZE_IN > DEPTH is clamped to DEPTH. index never wraps.
- Reset: asserting RST at any time, including mid-transfer, forces STARTER_STATE and:
  - DATA_OUT = 0
  - DATA_OUT_ENABLE = 0
  - READY = 0
  - BUSY = 0
  - index = 0, size = 0
  The partial transfer is abandoned with no READY.

## Timing
- All outputs are registered. Reset values: DATA_OUT=0, DATA_OUT_ENABLE=0, READY=0, BUSY=0.
- START accepted in cycle t:
  - DATA_OUT_ENABLE=1, DATA_OUT=mem[0] and BUSY=1 in cycle t+1.
  - Size 0: only READY=1 in cycle t+1.
- Throughput: one element per cycle while DATA_OUT_READY is held at 1. A size-N transfer with no stalls spans cycles t+1..t+N.
- Last transfer in cycle k: READY=1, DATA_OUT_ENABLE=0, BUSY=0 in cycle k+1. READY=0 again in cycle k+2.
- Back-to-back: START in cycle k+1 gives the next first element in cycle k+2.
- A buffer write in cycle t is readable by a START in cycle t+1.

## Test plan
- Load mem[0..3] = 10, 20, 30, 40. START with SIZE_IN=4 and DATA_OUT_READY held at 1 -> DATA_OUT = 10, 20, 30, 40 on consecutive cycles starting one cycle after START, then a single READY pulse and BUSY=0.
- Same load, SIZE_IN=3, DATA_OUT_READY toggling 1,0,0,1,1 -> each element held stable while stalled; exactly 10, 20, 30 delivered; READY the cycle after the third transfer.
- SIZE_IN=0 -> READY=1 in the cycle after START; DATA_OUT_ENABLE stays 0; BUSY stays 0.
- Fill all 16 entries with i+1. SIZE_IN=31 -> exactly 16 elements 1..16 sent, then READY. A second START during the transfer and a WRITE_ENABLE to mem[0] mid-transfer are both ignored (a later read of mem[0] returns 1).
- RST low after the second element of a size-4 transfer -> all outputs 0 immediately, no READY. After release, a START with SIZE_IN=2 sends 10, 20, showing the buffer contents were retained.
- START asserted in the READY cycle of a completed transfer -> accepted; the first element of the new transfer appears on the next cycle.
